algo_run_controller: RTL and testbench



---
 rtl/algo_run_controller_if.sv | 43 ++++
 rtl/algo_run_controller.sv | 153 +++++++++++++++
 tb/tb_algo_run_controller.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/algo_run_controller_if.sv
// Host/engine bundle for algo_run_controller.
// master = MMIO + engine side, slave = controller side.
interface algo_run_controller_if;
  logic [0:63] algorithm_requests;
  logic        report_algorithm_status_ack;
  logic        report_errors_ack;
  logic        engine_done;
  logic [0:63] engine_error;
  logic        engine_start;
  logic        engine_abort;
  logic [0:63] algorithm_status;
  logic [0:63] algorithm_status_done;
  logic [0:63] algorithm_running;
  logic [0:63] report_errors;

  modport master (
    output algorithm_requests,
    output report_algorithm_status_ack,
    output report_errors_ack,
    output engine_done,
    output engine_error,
    input  engine_start,
    input  engine_abort,
    input  algorithm_status,
    input  algorithm_status_done,
    input  algorithm_running,
    input  report_errors
  );

  modport slave (
    input  algorithm_requests,
    input  report_algorithm_status_ack,
    input  report_errors_ack,
    input  engine_done,
    input  engine_error,
    output engine_start,
    output engine_abort,
    output algorithm_status,
    output algorithm_status_done,
    output algorithm_running,
    output report_errors
  );
endinterface

// File: rtl/algo_run_controller.sv
// Runs one engine job per host request; reports state, done record, errors.
// Ports: clock, rstn (async low), bus (slave: requests/acks/engine in, status out).
module algo_run_controller #(
  parameter logic [31:0] WATCHDOG_CYCLES = 32'd0
) (
  input  logic                 clock,
  input  logic                 rstn,
  algo_run_controller_if.slave bus
);

  typedef enum logic [7:0] {
    S_IDLE  = 8'h01,
    S_START = 8'h02,
    S_RUN   = 8'h04,
    S_ABORT = 8'h08,
    S_DONE  = 8'h10
  } state_t;

  localparam logic [31:0] WD_M1 = WATCHDOG_CYCLES - 32'd1;
  localparam logic        WD_EN = (WATCHDOG_CYCLES != 32'd0);

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [30:0] r_job;
  logic        r_aborted;
  logic [0:63] r_err;
  logic        r_start;
  logic        r_abort;
  logic [0:63] r_status;
  logic [0:63] r_done;
  logic [0:63] r_running;

  state_t      w_next;
  logic [31:0] w_cnt_nxt;
  logic [31:0] w_cnt_inc;
  logic [30:0] w_job_nxt;
  logic        w_aborted_nxt;
  logic [0:63] w_err_set;
  logic [0:63] w_err_nxt;
  logic        w_start_req;
  logic        w_abort_req;
  logic        w_active;
  logic        w_unused;

  assign w_unused = ^{bus.algorithm_requests[0:61],
                      bus.engine_error[61:63]};

  // ABORT wins over START when both arrive together
  assign w_abort_req = bus.algorithm_requests[62];
  assign w_start_req = bus.algorithm_requests[63] & ~w_abort_req;

  assign w_cnt_inc = (r_cnt == 32'hFFFF_FFFF) ? r_cnt
                                              : r_cnt + 32'd1;

  always_comb begin
    w_next        = r_state;
    w_cnt_nxt     = r_cnt;
    w_aborted_nxt = r_aborted;
    w_err_set     = {bus.engine_error[0:60], 3'b000};
    if (w_start_req && (r_state != S_IDLE))
      w_err_set[63] = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        if (bus.engine_done)
          w_err_set[61] = 1'b1;
        if (w_start_req)
          w_next = S_START;
      end
      S_START: begin
        w_cnt_nxt = 32'd0;
        w_next    = S_RUN;
      end
      S_RUN: begin
        w_cnt_nxt = w_cnt_inc;
        if (bus.engine_done) begin
          w_next        = S_DONE;
          w_aborted_nxt = 1'b0;
        end else if (w_abort_req) begin
          w_next = S_ABORT;
        end else if (WD_EN && (r_cnt == WD_M1)) begin
          w_next        = S_ABORT;
          w_err_set[62] = 1'b1;
        end
      end
      S_ABORT: begin
        w_cnt_nxt = w_cnt_inc;
        if (bus.engine_done) begin
          w_next        = S_DONE;
          w_aborted_nxt = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.report_algorithm_status_ack)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // job count advances once, on the cycle DONE is entered
  assign w_job_nxt = ((w_next == S_DONE) && (r_state != S_DONE))
                   ? r_job + 31'd1 : r_job;

  // an ack clears old bits but never same-cycle new ones
  assign w_err_nxt = (bus.report_errors_ack ? 64'd0 : r_err)
                   | w_err_set;

  assign w_active = (w_next == S_START)
                  | (w_next == S_RUN)
                  | (w_next == S_ABORT);

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_cnt     <= 32'd0;
      r_job     <= 31'd0;
      r_aborted <= 1'b0;
      r_err     <= 64'd0;
      r_start   <= 1'b0;
      r_abort   <= 1'b0;
      r_status  <= 64'd0;
      r_done    <= 64'd0;
      r_running <= 64'd0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_job     <= w_job_nxt;
      r_aborted <= w_aborted_nxt;
      r_err     <= w_err_nxt;
      r_start   <= (w_next == S_START);
      r_abort   <= (w_next == S_ABORT) && (r_state != S_ABORT);
      r_status  <= {w_next, 24'd0, w_cnt_nxt};
      r_done    <= (w_next == S_DONE)
                 ? {w_aborted_nxt, w_job_nxt, w_cnt_nxt}
                 : 64'd0;
      r_running <= {63'd0, w_active};
    end
  end

  assign bus.engine_start          = r_start;
  assign bus.engine_abort          = r_abort;
  assign bus.algorithm_status      = r_status;
  assign bus.algorithm_status_done = r_done;
  assign bus.algorithm_running     = r_running;
  assign bus.report_errors         = r_err;

endmodule

// File: tb/tb_algo_run_controller.sv
// Directed + random bench for algo_run_controller against a job-level model.
// Drives at negedge, checks every output 1ns after each posedge.
module tb_algo_run_controller;

  localparam logic [31:0] WD = 32'd16;

  logic clock = 1'b0;
  logic rstn  = 1'b0;

  always #5 clock = ~clock;

  algo_run_controller_if bus ();

  algo_run_controller #(
    .WATCHDOG_CYCLES(WD)
  ) dut (
    .clock(clock),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int obs_abort;

  typedef enum int {P_IDLE, P_LAUNCH, P_RUN, P_STOP, P_DONE} ph_t;

  ph_t         m_ph;
  logic [63:0] m_cyc;
  logic [63:0] m_jobs;
  logic        m_ab;
  logic [0:63] m_err;

  logic        e_start;
  logic        e_abort;
  logic [0:63] e_run;
  logic [0:63] e_status;
  logic [0:63] e_done;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] code(ph_t p);
    case (p)
      P_IDLE:   return 8'h01;
      P_LAUNCH: return 8'h02;
      P_RUN:    return 8'h04;
      P_STOP:   return 8'h08;
      P_DONE:   return 8'h10;
      default:  return 8'h00;
    endcase
  endfunction

  task automatic m_reset();
    m_ph     = P_IDLE;
    m_cyc    = 0;
    m_jobs   = 0;
    m_ab     = 0;
    m_err    = 0;
    e_start  = 0;
    e_abort  = 0;
    e_run    = 0;
    e_status = 0;
    e_done   = 0;
  endtask

  task automatic m_finish(input logic ab);
    m_ph   = P_DONE;
    m_ab   = ab;
    m_jobs = (m_jobs + 1) % 64'h8000_0000;
  endtask

  task automatic m_bump();
    if (m_cyc < 64'hFFFF_FFFF) m_cyc = m_cyc + 1;
  endtask

  task automatic m_step(input logic [0:63] req, input logic sack,
                        input logic eack, input logic edone,
                        input logic [0:63] eerr);
    logic go, stop;
    logic [0:63] nerr;
    ph_t prev;
    stop = req[62];
    go   = req[63] && !stop;
    nerr = eerr;
    nerr[61] = 0;
    nerr[62] = 0;
    nerr[63] = 0;
    if (go && m_ph != P_IDLE) nerr[63] = 1;
    prev = m_ph;
    case (m_ph)
      P_IDLE: begin
        if (edone) nerr[61] = 1;
        if (go) m_ph = P_LAUNCH;
      end
      P_LAUNCH: begin
        m_cyc = 0;
        m_ph  = P_RUN;
      end
      P_RUN: begin
        m_bump();
        if (edone) m_finish(1'b0);
        else if (stop) m_ph = P_STOP;
        else if (WD != 0 && m_cyc == 64'(WD)) begin
          m_ph = P_STOP;
          nerr[62] = 1;
        end
      end
      P_STOP: begin
        m_bump();
        if (edone) m_finish(1'b1);
      end
      P_DONE: if (sack) m_ph = P_IDLE;
      default: m_ph = P_IDLE;
    endcase
    m_err    = (eack ? 64'd0 : m_err) | nerr;
    e_start  = (m_ph == P_LAUNCH);
    e_abort  = (m_ph == P_STOP) && (prev != P_STOP);
    e_run    = (m_ph == P_LAUNCH || m_ph == P_RUN || m_ph == P_STOP)
             ? 64'd1 : 64'd0;
    e_status = {code(m_ph), 24'h0, m_cyc[31:0]};
    e_done   = (m_ph == P_DONE) ? {m_ab, m_jobs[30:0], m_cyc[31:0]}
                                : 64'd0;
  endtask

  task automatic cyc(input logic [0:63] req, input logic sack,
                     input logic eack, input logic edone,
                     input logic [0:63] eerr);
    @(negedge clock);
    bus.algorithm_requests          = req;
    bus.report_algorithm_status_ack = sack;
    bus.report_errors_ack           = eack;
    bus.engine_done                 = edone;
    bus.engine_error                = eerr;
    m_step(req, sack, eack, edone, eerr);
    @(posedge clock);
    #1;
    obs_abort += int'(bus.engine_abort);
    chk("start",   64'(bus.engine_start), 64'(e_start));
    chk("abort",   64'(bus.engine_abort), 64'(e_abort));
    chk("running", bus.algorithm_running, e_run);
    chk("status",  bus.algorithm_status, e_status);
    chk("done",    bus.algorithm_status_done, e_done);
    chk("errors",  bus.report_errors, m_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    bus.algorithm_requests          = 0;
    bus.report_algorithm_status_ack = 0;
    bus.report_errors_ack           = 0;
    bus.engine_done                 = 0;
    bus.engine_error                = 0;
    #2 rstn = 1'b0;
    #1;
    chk("rst_start",   64'(bus.engine_start), 64'd0);
    chk("rst_abort",   64'(bus.engine_abort), 64'd0);
    chk("rst_running", bus.algorithm_running, 64'd0);
    chk("rst_status",  bus.algorithm_status, 64'd0);
    chk("rst_done",    bus.algorithm_status_done, 64'd0);
    chk("rst_errors",  bus.report_errors, 64'd0);
    m_reset();
    @(posedge clock);
    #2 rstn = 1'b1;
  endtask

  logic [0:63] w_req;
  logic [0:63] w_err;

  initial begin
    bus.algorithm_requests          = 0;
    bus.report_algorithm_status_ack = 0;
    bus.report_errors_ack           = 0;
    bus.engine_done                 = 0;
    bus.engine_error                = 0;
    m_reset();
    obs_abort = 0;

    // basic job: done on the 10th RUNNING cycle
    do_reset();
    idle(1);
    chk("idle_status", bus.algorithm_status, 64'h0100_0000_0000_0000);
    cyc(64'h1, 0, 0, 0, 0);
    chk("basic_start", 64'(bus.engine_start), 64'd1);
    chk("basic_run", bus.algorithm_running, 64'd1);
    idle(1);
    chk("basic_code", 64'(bus.algorithm_status[0:7]), 64'h04);
    idle(9);
    cyc(0, 0, 0, 1, 0);
    chk("basic_done", bus.algorithm_status_done, 64'h0000_0001_0000_000A);
    cyc(0, 1, 0, 0, 0);
    chk("basic_ack_done", bus.algorithm_status_done, 64'd0);
    chk("basic_ack_code", 64'(bus.algorithm_status[0:7]), 64'h01);

    // host abort after 5 RUNNING cycles, done 3 cycles later
    do_reset();
    obs_abort = 0;
    cyc(64'h1, 0, 0, 0, 0);
    idle(6);
    cyc(64'h2, 0, 0, 0, 0);
    idle(2);
    cyc(0, 0, 0, 1, 0);
    chk("habort_done", bus.algorithm_status_done, 64'h8000_0001_0000_0009);
    chk("habort_pulses", 64'(obs_abort), 64'd1);
    cyc(0, 1, 0, 0, 0);

    // watchdog fires after 16 RUNNING cycles
    do_reset();
    cyc(64'h1, 0, 0, 0, 0);
    idle(16);
    idle(1);
    chk("wd_abort", 64'(bus.engine_abort), 64'd1);
    chk("wd_errors", bus.report_errors, 64'h0000_0000_0000_0002);
    idle(1);
    cyc(0, 0, 0, 1, 0);
    chk("wd_done0", 64'(bus.algorithm_status_done[0]), 64'd1);
    cyc(0, 1, 1, 0, 0);
    chk("wd_err_clr", bus.report_errors, 64'd0);

    // start while busy, then error/ack race
    do_reset();
    cyc(64'h1, 0, 0, 0, 0);
    idle(2);
    cyc(64'h1, 0, 0, 0, 0);
    chk("busy_err", bus.report_errors, 64'h1);
    chk("busy_nostart", 64'(bus.engine_start), 64'd0);
    idle(1);
    cyc(0, 0, 1, 0, 0);
    chk("busy_clr", bus.report_errors, 64'd0);
    cyc(64'h1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 64'h8000_0000_0000_0000);
    chk("race_err", bus.report_errors, 64'h8000_0000_0000_0000);

    // simultaneous events and reset mid-job
    do_reset();
    cyc(64'h3, 0, 0, 0, 0);
    chk("both_nostart", 64'(bus.engine_start), 64'd0);
    chk("both_idle", 64'(bus.algorithm_status[0:7]), 64'h01);
    cyc(64'h1, 0, 0, 0, 0);
    idle(2);
    cyc(64'h2, 0, 0, 1, 0);
    chk("race_code", 64'(bus.algorithm_status[0:7]), 64'h10);
    chk("race_ab", 64'(bus.algorithm_status_done[0]), 64'd0);
    cyc(0, 1, 0, 0, 0);
    cyc(64'h1, 0, 0, 0, 0);
    idle(3);
    chk("pre_rst_run", bus.algorithm_running, 64'd1);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int k;
      logic sack, eack, edone;
      if (i == 1500) do_reset();
      k = $urandom_range(0, 15);
      w_req = 0;
      if ($urandom_range(0, 3) == 0) w_req = {$urandom, $urandom};
      w_req[62] = (k == 1 || k == 3);
      w_req[63] = (k == 0 || k == 2 || k == 3);
      sack  = ($urandom_range(0, 3) == 0);
      eack  = ($urandom_range(0, 19) == 0);
      edone = ($urandom_range(0, 5) == 0);
      w_err = 0;
      if ($urandom_range(0, 29) == 0)
        w_err[$urandom_range(0, 63)] = 1'b1;
      cyc(w_req, sack, eack, edone, w_err);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
